// File: rtl/wrapper_pkg.sv
// Shared types and default widths for the hash-wrapper digest packetiser and its valid filter.
package wrapper_pkg;

   localparam int unsigned DIGEST_W_DEF = 256;
   localparam int unsigned PKT_W_DEF    = 64;
   localparam int unsigned DEPTH_DEF    = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } pkt_state_t;

   // LSB position of beat k inside a digest; beat 0 is the most-significant word.
   function automatic int unsigned beat_lsb(input int unsigned k,
                                            input int unsigned digest_w,
                                            input int unsigned pkt_w);
      return digest_w - ((k + 1) * pkt_w);
   endfunction

endpackage

// File: rtl/wrapper_sync_fifo.sv
// Flop-array FIFO for captured digests; exposes both the head and the entry behind it.
module wrapper_sync_fifo #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [WIDTH-1:0]         rd_next_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (wr_en_i && !rd_en_i) begin
         count_d = count_q + 1'b1;
      end else if (!wr_en_i && rd_en_i) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign rd_next_o = mem_q[PTR_W'(rd_ptr_q + 1'b1)];
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign level_o   = count_q;

endmodule

// File: rtl/wrapper_digest_packetiser.sv
// Captures final digests from the valid filter, buffers them and streams each one out as
// PKT_W-bit valid/ready/last beats, most-significant word first; flags dropped digests.
module wrapper_digest_packetiser
   import wrapper_pkg::*;
#(
   parameter int unsigned DIGEST_W = DIGEST_W_DEF,
   parameter int unsigned PKT_W    = PKT_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DIGEST_W-1:0]     data_out,
   input  logic                    payload_out_valid,
   output logic [PKT_W-1:0]        packet_data,
   output logic                    packet_data_last,
   output logic                    packet_data_valid,
   input  logic                    packet_data_ready,
   input  logic                    status_clear,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow
);

   localparam int unsigned BEATS  = DIGEST_W / PKT_W;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic              SINGLE    = (BEATS == 1);

   function automatic logic [PKT_W-1:0] beat_word(input logic [DIGEST_W-1:0] d,
                                                  input logic [BEAT_W-1:0]   k);
      return PKT_W'(d >> beat_lsb(32'(k), DIGEST_W, PKT_W));
   endfunction

   pkt_state_t          state_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [PKT_W-1:0]    data_q;
   logic                last_q;
   logic                valid_q;
   logic                overflow_q;

   logic [DIGEST_W-1:0] fifo_head;
   logic [DIGEST_W-1:0] fifo_next;
   logic [DIGEST_W-1:0] next_digest;
   logic                fifo_full;
   logic                fifo_empty;
   logic                handshake;
   logic                at_last;
   logic                pop;
   logic                wr_en;
   logic                drop;

   assign handshake = (state_q == SEND) && valid_q && packet_data_ready;
   assign at_last   = (beat_q == LAST_BEAT);
   assign pop       = handshake && at_last;
   // A full FIFO still accepts when its head retires on this same edge.
   assign wr_en     = payload_out_valid && (!fifo_full || pop);
   assign drop      = payload_out_valid && fifo_full && !pop;
   // With only the retiring entry held, the follow-on digest is the one arriving now.
   assign next_digest = (fifo_level > CNT_W'(1)) ? fifo_next : data_out;

   wrapper_sync_fifo #(
      .WIDTH (DIGEST_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (data_out),
      .rd_en_i   (pop),
      .rd_data_o (fifo_head),
      .rd_next_o (fifo_next),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         data_q     <= '0;
         last_q     <= 1'b0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (status_clear) begin
            overflow_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  data_q  <= beat_word(fifo_head, '0);
                  beat_q  <= '0;
                  last_q  <= SINGLE;
                  valid_q <= 1'b1;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (handshake) begin
                  if (!at_last) begin
                     beat_q <= beat_q + 1'b1;
                     data_q <= beat_word(fifo_head, beat_q + 1'b1);
                     last_q <= ((beat_q + 1'b1) == LAST_BEAT);
                  end else if ((fifo_level > CNT_W'(1)) || wr_en) begin
                     data_q <= beat_word(next_digest, '0);
                     beat_q <= '0;
                     last_q <= SINGLE;
                  end else begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     beat_q  <= '0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign packet_data       = data_q;
   assign packet_data_last  = last_q;
   assign packet_data_valid = valid_q;
   assign overflow          = overflow_q;

endmodule

// File: tb/tb_wrapper_digest_packetiser.sv
// Bench for wrapper_digest_packetiser: fixed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based model of the digest stream.
module tb_wrapper_digest_packetiser;

   localparam int unsigned DIGEST_W = 256;
   localparam int unsigned PKT_W    = 64;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned BEATS    = DIGEST_W / PKT_W;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [DIGEST_W-1:0]  data_out = '0;
   logic                 payload_out_valid = 1'b0;
   logic [PKT_W-1:0]     packet_data;
   logic                 packet_data_last;
   logic                 packet_data_valid;
   logic                 packet_data_ready = 1'b0;
   logic                 status_clear = 1'b0;
   logic [2:0]           fifo_level;
   logic                 overflow;

   always #5 clk = ~clk;

   wrapper_digest_packetiser #(
      .DIGEST_W (DIGEST_W),
      .PKT_W    (PKT_W),
      .DEPTH    (DEPTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .data_out          (data_out),
      .payload_out_valid (payload_out_valid),
      .packet_data       (packet_data),
      .packet_data_last  (packet_data_last),
      .packet_data_valid (packet_data_valid),
      .packet_data_ready (packet_data_ready),
      .status_clear      (status_clear),
      .fifo_level        (fifo_level),
      .overflow          (overflow)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [255:0] d, input int k);
      return d[255 - 64*k -: 64];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of expected beats, digest count and sticky overflow.
   logic [63:0] exp_beats[$];
   int          m_count;
   int          m_beat;
   int          cur_count;
   logic        m_ovf;
   logic        m_retire;
   logic        m_drop;
   logic        prev_stall;
   logic        prev_start;
   logic [63:0] prev_data;
   logic        prev_last;
   logic [63:0] w;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         exp_beats.delete();
         m_count    = 0;
         m_beat     = 0;
         m_ovf      = 1'b0;
         prev_stall = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", packet_data_valid, 1'b1);
            chk("hold_data", packet_data, prev_data);
            chk("hold_last", packet_data_last, prev_last);
         end
         if (prev_start) chk("start_latency", packet_data_valid, 1'b1);
         chk("model_level", fifo_level, m_count);
         chk("model_overflow", overflow, m_ovf);
         if (packet_data_valid) chk("valid_needs_entry", (fifo_level != 0), 1'b1);
         cur_count = m_count;
         m_retire  = 1'b0;
         if (packet_data_valid && packet_data_ready) begin
            chk("beat_expected", (exp_beats.size() > 0), 1'b1);
            if (exp_beats.size() > 0) begin
               w = exp_beats.pop_front();
               chk("beat_data", packet_data, w);
               chk("beat_last", packet_data_last, (m_beat == BEATS - 1));
               m_retire = (m_beat == BEATS - 1);
               m_beat   = (m_beat + 1) % BEATS;
            end
         end
         m_drop = payload_out_valid && (m_count == DEPTH) && !m_retire;
         if (payload_out_valid && !m_drop) begin
            for (int k = 0; k < BEATS; k++) exp_beats.push_back(word_of(data_out, k));
            m_count++;
         end
         if (m_retire) m_count--;
         if (m_drop) m_ovf = 1'b1;
         else if (status_clear) m_ovf = 1'b0;
         prev_stall = packet_data_valid && !packet_data_ready;
         prev_data  = packet_data;
         prev_last  = packet_data_last;
         prev_start = !packet_data_valid && (cur_count > 0);
      end
   end

   typedef struct {
      logic        pv;
      logic        rdy;
      logic        e_valid;
      logic        e_last;
      logic        chk_data;
      logic [63:0] e_data;
      logic [2:0]  e_level;
      logic        e_ovf;
   } vec_t;

   function automatic vec_t mkv(input logic pv, input logic rdy, input logic ev, input logic el,
                                input logic cd, input logic [63:0] ed, input logic [2:0] elv,
                                input logic eo);
      vec_t v;
      v.pv = pv; v.rdy = rdy; v.e_valid = ev; v.e_last = el;
      v.chk_data = cd; v.e_data = ed; v.e_level = elv; v.e_ovf = eo;
      return v;
   endfunction

   localparam logic [255:0] D1 =
      256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_0A0B0C0D0E0FCDEF;

   vec_t         tbl[8];
   logic [255:0] d2[5];
   logic [255:0] e3[5];
   logic [255:0] f6[4];
   logic [255:0] g5;
   int           got;
   int           lasts;
   int           cyc;
   int           sent;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      tbl[0] = mkv(1, 1, 0, 0, 1, 64'h0,                0, 0);
      tbl[1] = mkv(0, 1, 0, 0, 1, 64'h0,                1, 0);
      tbl[2] = mkv(0, 1, 1, 0, 1, 64'h0123456789ABCDEF, 1, 0);
      tbl[3] = mkv(0, 1, 1, 0, 1, 64'h1122334455667788, 1, 0);
      tbl[4] = mkv(0, 1, 1, 0, 1, 64'h99AABBCCDDEEFF00, 1, 0);
      tbl[5] = mkv(0, 1, 1, 1, 1, 64'h0A0B0C0D0E0FCDEF, 1, 0);
      tbl[6] = mkv(0, 1, 0, 0, 0, 64'h0,                0, 0);
      tbl[7] = mkv(0, 1, 0, 0, 0, 64'h0,                0, 0);

      repeat (3) tick();
      rst = 1'b0;

      // Single digest, ready high: reset state then four beats MSW first.
      for (int r = 0; r < 8; r++) begin
         chk($sformatf("t1_valid_r%0d", r), packet_data_valid, tbl[r].e_valid);
         chk($sformatf("t1_last_r%0d", r), packet_data_last, tbl[r].e_last);
         chk($sformatf("t1_level_r%0d", r), fifo_level, tbl[r].e_level);
         chk($sformatf("t1_ovf_r%0d", r), overflow, tbl[r].e_ovf);
         if (tbl[r].chk_data) chk($sformatf("t1_data_r%0d", r), packet_data, tbl[r].e_data);
         payload_out_valid = tbl[r].pv;
         packet_data_ready = tbl[r].rdy;
         data_out          = tbl[r].pv ? D1 : rand256();
         tick();
      end

      // Stalled consumer: five digests, fifth dropped, then 16 back-to-back beats.
      packet_data_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d2[i] = rand256();
         payload_out_valid = 1'b1;
         data_out = d2[i];
         tick();
      end
      payload_out_valid = 1'b0;
      tick();
      chk("t2_level_full", fifo_level, 3'd4);
      chk("t2_overflow", overflow, 1'b1);
      packet_data_ready = 1'b1;
      got = 0; lasts = 0; cyc = 0;
      while (got < 16 && cyc < 40) begin
         if (packet_data_valid) begin
            chk($sformatf("t2_beat%0d", got), packet_data, word_of(d2[got / 4], got % 4));
            lasts += int'(packet_data_last);
            got++;
         end
         tick();
         cyc++;
      end
      chk("t2_beat_count", got, 16);
      chk("t2_no_bubble", cyc, 16);
      chk("t2_last_count", lasts, 4);
      chk("t2_level_empty", fifo_level, 3'd0);
      chk("t2_idle", packet_data_valid, 1'b0);
      status_clear = 1'b1;
      tick();
      status_clear = 1'b0;
      chk("t2_cleared", overflow, 1'b0);

      // Full FIFO accepts a pulse landing on the head's final-beat handshake.
      packet_data_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e3[i] = rand256();
         payload_out_valid = 1'b1;
         data_out = e3[i];
         tick();
      end
      payload_out_valid = 1'b0;
      tick();
      chk("t3_level_full", fifo_level, 3'd4);
      packet_data_ready = 1'b1;
      cyc = 0;
      while (!(packet_data_valid && packet_data_last) && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("t3_reach_last", (packet_data_valid && packet_data_last), 1'b1);
      e3[4] = rand256();
      payload_out_valid = 1'b1;
      data_out = e3[4];
      tick();
      payload_out_valid = 1'b0;
      chk("t3_level_stays", fifo_level, 3'd4);
      chk("t3_no_overflow", overflow, 1'b0);
      chk("t3_next_head", packet_data, word_of(e3[1], 0));
      chk("t3_next_valid", packet_data_valid, 1'b1);
      cyc = 0;
      while ((packet_data_valid || fifo_level != 0) && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("t3_drained", (!packet_data_valid && fifo_level == 0), 1'b1);

      // Random ready over three digests.
      sent = 0; cyc = 0;
      while ((sent < 3 || fifo_level != 0 || packet_data_valid) && cyc < 300) begin
         packet_data_ready = 1'($urandom_range(0, 1));
         if (sent < 3 && $urandom_range(0, 3) == 0) begin
            payload_out_valid = 1'b1;
            data_out = rand256();
            sent++;
         end else begin
            payload_out_valid = 1'b0;
            data_out = rand256();
         end
         tick();
         cyc++;
      end
      payload_out_valid = 1'b0;
      chk("t4_done", (sent == 3 && fifo_level == 0 && !packet_data_valid), 1'b1);

      // Random soak with drops and clears.
      for (int i = 0; i < 400; i++) begin
         packet_data_ready = 1'($urandom_range(0, 1));
         payload_out_valid = ($urandom_range(0, 2) == 0);
         status_clear      = ($urandom_range(0, 15) == 0);
         data_out          = rand256();
         tick();
      end
      payload_out_valid = 1'b0;
      status_clear = 1'b0;
      packet_data_ready = 1'b1;
      cyc = 0;
      while ((packet_data_valid || fifo_level != 0) && cyc < 100) begin
         tick();
         cyc++;
      end
      chk("soak_drained", exp_beats.size(), 0);
      status_clear = 1'b1;
      tick();
      status_clear = 1'b0;
      chk("soak_cleared", overflow, 1'b0);

      // status_clear coinciding with a drop: set wins; clear alone then takes effect.
      packet_data_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         f6[i] = rand256();
         payload_out_valid = 1'b1;
         data_out = f6[i];
         tick();
      end
      payload_out_valid = 1'b1;
      status_clear = 1'b1;
      data_out = rand256();
      tick();
      payload_out_valid = 1'b0;
      status_clear = 1'b0;
      chk("t6_set_wins", overflow, 1'b1);
      status_clear = 1'b1;
      tick();
      status_clear = 1'b0;
      chk("t6_clear", overflow, 1'b0);

      // Reset mid-digest after beat 1.
      payload_out_valid = 1'b1;
      data_out = rand256();
      tick();
      payload_out_valid = 1'b0;
      chk("t5_pre_overflow", overflow, 1'b1);
      packet_data_ready = 1'b1;
      tick();
      tick();
      chk("t5_mid_digest", packet_data, word_of(f6[0], 2));
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", packet_data_valid, 1'b0);
      chk("t5_rst_level", fifo_level, 3'd0);
      chk("t5_rst_overflow", overflow, 1'b0);
      chk("t5_rst_last", packet_data_last, 1'b0);
      chk("t5_rst_data", packet_data, 64'h0);
      tick();
      tick();
      rst = 1'b0;
      g5 = rand256();
      payload_out_valid = 1'b1;
      data_out = g5;
      tick();
      payload_out_valid = 1'b0;
      cyc = 0;
      while (!packet_data_valid && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("t5_restart_valid", packet_data_valid, 1'b1);
      chk("t5_restart_beat0", packet_data, word_of(g5, 0));
      cyc = 0;
      while ((packet_data_valid || fifo_level != 0) && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("t5_drained", exp_beats.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
